ili9341_bus_arbiter: RTL and testbench
======================================

ILI9341_BUS_ARBITER -- requirements
Module: ili9341_bus_arbiter

Interface
REQ-001 SHALL provide parameter WR_LOW_CYCLES, default 2, clocks WR is held low per byte (min 1).
REQ-002 SHALL provide parameter WR_HIGH_CYCLES, default 2, clocks WR is held high after each byte (min 1).
REQ-003 SHALL provide parameter CS_IDLE_CYCLES, default 8, idle clocks in HOLD before CS is released (min 1).
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 cmdValid  input  1  command/parameter byte available.
REQ-007 cmdByte  input  9  bit 8 = DC (0 command, 1 data), bits 7:0 bus byte.
REQ-008 cmdLast  input  1  final byte of the current command transaction.
REQ-009 cmdReady  output  1  one-cycle pulse: cmd byte accepted this edge.
REQ-010 pixelValid  input  1  RGB565 pixel available.
REQ-011 pixelDataIn  input  16  RGB565 pixel.
REQ-012 pixelReady  output  1  one-cycle pulse: pixel accepted this edge.
REQ-013 tftParallelPort  output  8  8080-I data bus.
REQ-014 tftChipSelect, tftWriteEnable, tftDataCmd  output  1 each  CS (active low), WR (active low), DC (1 data).
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 States SHALL be IDLE, SETUP, WR_LOW, WR_HIGH, HOLD.
REQ-017 Arbitration SHALL occur only in IDLE and HOLD; a grant transfers to SETUP on the next edge.
REQ-018 cmd SHALL win over pixel when both valid and no lock is active.
REQ-019 Accepting a cmd byte with cmdLast=0 SHALL set lock; lock SHALL clear when a cmd byte with cmdLast=1 is accepted.
REQ-020 While lock set, pixelValid SHALL be ignored and the HOLD idle counter SHALL not advance (CS stays low).
REQ-021 cmdReady/pixelReady SHALL be combinational: high in IDLE/HOLD exactly when that port is granted; never both high; data sampled on that edge.
REQ-022 SETUP (1 clock): CS=0, WR=1, port and DC driven with the byte to send.
REQ-023 WR_LOW SHALL last WR_LOW_CYCLES clocks with WR=0, data/DC/CS stable.
REQ-024 WR_HIGH SHALL last WR_HIGH_CYCLES clocks with WR=1, data/DC stable.
REQ-025 Pixel SHALL be sent MSB byte (bits 15:8) then LSB byte (7:0), DC=1; after MSB WR_HIGH go directly to SETUP with LSB, no arbitration; a pixel is never split.
REQ-026 After the last byte's WR_HIGH state SHALL go to HOLD with idle counter cleared.
REQ-027 In HOLD with no grant and no lock, counter increments; at CS_IDLE_CYCLES state SHALL go to IDLE and CS SHALL be 1 the following cycle.
REQ-028 Per-byte cost SHALL be exactly 1+WR_LOW_CYCLES+WR_HIGH_CYCLES clocks; pixel cost twice that.
REQ-029 Counters SHALL be sized from parameters; no wrap occurs in normal operation.
REQ-030 Valid deasserted mid-transfer SHALL not affect the byte in flight (data latched at grant).

Reset
REQ-031 reset_n low SHALL asynchronously force state IDLE, lock 0, counters 0, tftParallelPort 0x00, CS 1, WR 1, DC 1, cmdReady 0, pixelReady 0, busy 0.
REQ-032 Reset mid-transfer SHALL abandon the byte; no ready is issued for it afterward; first grant after release follows REQ-017.

Verification
REQ-033 Single cmd: cmdByte=0x02A, cmdLast=1 in IDLE -> cmdReady pulse; SETUP CS=0 DC=0 port=0x2A; WR low 2 clocks, high 2; HOLD 8 clocks; CS=1.
REQ-034 Pixel 0xF81F -> pixelReady pulse; port 0xF8 then 0x1F, DC=1, two WR low pulses, 10 clocks total to HOLD.
REQ-035 Simultaneous cmdValid (0x12C, last=1) and pixelValid in IDLE -> cmd granted first, pixel granted in following HOLD.
REQ-036 cmdValid asserted during pixel MSB WR_LOW -> not granted until LSB WR_HIGH done; CS never rises between.
REQ-037 Lock: cmd 0x02B last=0, then cmd idle 20 clocks with pixelValid high -> no pixelReady, CS stays 0; cmd 0x100 last=1 accepted, then pixel granted.
REQ-038 reset_n low during WR_LOW of 0x0FF -> WR=1, CS=1, port=0x00 immediately, busy 0; after release resends nothing until new valid.

Source files
------------

// File: rtl/ili9341_bus_arbiter.sv
// ILI9341 8080-I parallel bus arbiter.
// Shares one 8-bit write-only TFT bus between a command/parameter stream and
// an RGB565 pixel stream. Commands win ties. A multi-byte command holds the
// bus (lock) until its final byte. Chip select stays asserted for a short idle
// window after each transfer so that back-to-back traffic needs no CS cycling.
module ili9341_bus_arbiter #(
  parameter int WR_LOW_CYCLES  = 2,  // clocks WR is held low per byte (>= 1)
  parameter int WR_HIGH_CYCLES = 2,  // clocks WR is held high after each byte (>= 1)
  parameter int CS_IDLE_CYCLES = 8   // idle clocks in HOLD before CS is released (>= 1)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmdValid,
  input  logic [8:0]  cmdByte,
  input  logic        cmdLast,
  output logic        cmdReady,
  input  logic        pixelValid,
  input  logic [15:0] pixelDataIn,
  output logic        pixelReady,
  output logic [7:0]  tftParallelPort,
  output logic        tftChipSelect,
  output logic        tftWriteEnable,
  output logic        tftDataCmd,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WR_LOW,
    WR_HIGH,
    HOLD
  } state_t;

  // One phase counter serves both WR strobe phases, so size it for the longer.
  localparam int PHASE_MAX = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int IDLE_W    = $clog2(CS_IDLE_CYCLES + 1);

  localparam logic [PHASE_W-1:0] LOW_LAST  = PHASE_W'(WR_LOW_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HIGH_LAST = PHASE_W'(WR_HIGH_CYCLES - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(CS_IDLE_CYCLES - 1);

  state_t               state, stateNext;
  logic [PHASE_W-1:0]   phaseCnt, phaseNext;
  logic [IDLE_W-1:0]    idleCnt, idleNext;
  logic                 lock, lockNext;
  logic [7:0]           portReg, portNext;
  logic                 dcReg, dcNext;
  logic [7:0]           lsbByte, lsbNext;
  logic                 lsbPending, pendingNext;
  logic                 csReg, wrReg;
  logic                 arbWindow, cmdGrant, pixelGrant;

  // Arbitration: only in IDLE/HOLD, command has priority, lock shuts out pixels.
  always_comb begin
    arbWindow  = (state == IDLE) || (state == HOLD);
    // NOTE: the grants are combinational and feed the ready outputs directly,
    // so they are gated with reset_n to keep both readies low during reset.
    cmdGrant   = reset_n && arbWindow && cmdValid;
    pixelGrant = reset_n && arbWindow && pixelValid && !cmdValid && !lock;
  end

  // Next-state and datapath-next logic for the transfer sequencer.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    stateNext   = state;
    phaseNext   = phaseCnt;
    idleNext    = idleCnt;
    lockNext    = lock;
    portNext    = portReg;
    dcNext      = dcReg;
    lsbNext     = lsbByte;
    pendingNext = lsbPending;

    unique case (state)
      IDLE, HOLD: begin
        if (cmdGrant) begin
          stateNext   = SETUP;
          portNext    = cmdByte[7:0];
          dcNext      = cmdByte[8];
          lockNext    = !cmdLast;
          pendingNext = 1'b0;
        end else if (pixelGrant) begin
          stateNext   = SETUP;
          portNext    = pixelDataIn[15:8];
          dcNext      = 1'b1;
          lsbNext     = pixelDataIn[7:0];
          pendingNext = 1'b1;
        end else if (state == HOLD && !lock) begin
          if (idleCnt == IDLE_LAST) begin
            stateNext = IDLE;
            idleNext  = '0;
          end else begin
            idleNext = idleCnt + 1'b1;
          end
        end
      end

      SETUP: begin
        stateNext = WR_LOW;
        phaseNext = '0;
      end

      WR_LOW: begin
        if (phaseCnt == LOW_LAST) begin
          stateNext = WR_HIGH;
          phaseNext = '0;
        end else begin
          phaseNext = phaseCnt + 1'b1;
        end
      end

      WR_HIGH: begin
        if (phaseCnt == HIGH_LAST) begin
          phaseNext = '0;
          if (lsbPending) begin
            // Second half of a pixel goes straight out; a pixel is never split.
            stateNext   = SETUP;
            portNext    = lsbByte;
            pendingNext = 1'b0;
          end else begin
            stateNext = HOLD;
            idleNext  = '0;
          end
        end else begin
          phaseNext = phaseCnt + 1'b1;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      phaseCnt   <= '0;
      idleCnt    <= '0;
      lock       <= 1'b0;
      portReg    <= 8'h00;
      dcReg      <= 1'b1;
      lsbByte    <= 8'h00;
      lsbPending <= 1'b0;
      csReg      <= 1'b1;
      wrReg      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values computed by the combinational block.
      state      <= stateNext;
      phaseCnt   <= phaseNext;
      idleCnt    <= idleNext;
      lock       <= lockNext;
      portReg    <= portNext;
      dcReg      <= dcNext;
      lsbByte    <= lsbNext;
      lsbPending <= pendingNext;
      // NOTE: CS and WR are registered from the next state rather than decoded
      // from the state vector, so the panel strobes cannot glitch.
      csReg      <= (stateNext == IDLE);
      wrReg      <= (stateNext != WR_LOW);
    end
  end

  // Output mapping.
  always_comb begin
    cmdReady        = cmdGrant;
    pixelReady      = pixelGrant;
    tftParallelPort = portReg;
    tftDataCmd      = dcReg;
    tftChipSelect   = csReg;
    tftWriteEnable  = wrReg;
    busy            = (state != IDLE);
  end

endmodule

// File: tb/tb_ili9341_bus_arbiter.sv
// Testbench for ili9341_bus_arbiter: a cycle-by-cycle vector table for the
// basic command, pixel and tie-break transfers, then hand-written sequences
// for mid-transfer requests, command lock and reset during a write strobe.
module tb_ili9341_bus_arbiter;

  localparam int WL = 2;
  localparam int WH = 2;
  localparam int CI = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmdValid;
  logic [8:0]  cmdByte;
  logic        cmdLast;
  logic        cmdReady;
  logic        pixelValid;
  logic [15:0] pixelDataIn;
  logic        pixelReady;
  logic [7:0]  tftParallelPort;
  logic        tftChipSelect;
  logic        tftWriteEnable;
  logic        tftDataCmd;
  logic        busy;

  int nCompared = 0;
  int nFailed   = 0;

  ili9341_bus_arbiter #(
    .WR_LOW_CYCLES (WL),
    .WR_HIGH_CYCLES(WH),
    .CS_IDLE_CYCLES(CI)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmdValid       (cmdValid),
    .cmdByte        (cmdByte),
    .cmdLast        (cmdLast),
    .cmdReady       (cmdReady),
    .pixelValid     (pixelValid),
    .pixelDataIn    (pixelDataIn),
    .pixelReady     (pixelReady),
    .tftParallelPort(tftParallelPort),
    .tftChipSelect  (tftChipSelect),
    .tftWriteEnable (tftWriteEnable),
    .tftDataCmd     (tftDataCmd),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        cv;
    logic [8:0]  cb;
    logic        cl;
    logic        pv;
    logic [15:0] pd;
    logic        eCmdReady;
    logic        ePixReady;
    logic        eCs;
    logic        eWr;
    logic        eDc;
    logic [7:0]  ePort;
    logic        eBusy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string tag, input logic cv, input logic [8:0] cb,
                              input logic cl, input logic pv, input logic [15:0] pd,
                              input logic cr, input logic pr, input logic cs,
                              input logic wr, input logic dc, input logic [7:0] port,
                              input logic bsy);
    vec_t v;
    v.tag = tag; v.cv = cv; v.cb = cb; v.cl = cl; v.pv = pv; v.pd = pd;
    v.eCmdReady = cr; v.ePixReady = pr; v.eCs = cs; v.eWr = wr;
    v.eDc = dc; v.ePort = port; v.eBusy = bsy;
    return v;
  endfunction

  // One byte on the bus: SETUP, WL clocks with WR low, WH clocks with WR high.
  task automatic addByte(input string tag, input logic pv, input logic [15:0] pd,
                         input logic dc, input logic [7:0] port);
    vecs.push_back(mk({tag, "_setup"}, 0, 9'h0, 0, pv, pd, 0, 0, 0, 1, dc, port, 1));
    for (int i = 0; i < WL; i++)
      vecs.push_back(mk({tag, "_wrlow"}, 0, 9'h0, 0, pv, pd, 0, 0, 0, 0, dc, port, 1));
    for (int i = 0; i < WH; i++)
      vecs.push_back(mk({tag, "_wrhigh"}, 0, 9'h0, 0, pv, pd, 0, 0, 0, 1, dc, port, 1));
  endtask

  task automatic addHold(input string tag, input int n, input logic dc, input logic [7:0] port);
    for (int i = 0; i < n; i++)
      vecs.push_back(mk({tag, "_hold"}, 0, 9'h0, 0, 0, 16'h0, 0, 0, 0, 1, dc, port, 1));
  endtask

  task automatic checkBus(input string tag, input logic cs, input logic wr,
                          input logic dc, input logic [7:0] port, input logic bsy);
    check({tag, "_cs"},   16'(tftChipSelect),   16'(cs));
    check({tag, "_wr"},   16'(tftWriteEnable),  16'(wr));
    check({tag, "_dc"},   16'(tftDataCmd),      16'(dc));
    check({tag, "_port"}, 16'(tftParallelPort), 16'(port));
    check({tag, "_busy"}, 16'(busy),            16'(bsy));
  endtask

  task automatic clearInputs();
    cmdValid = 1'b0; cmdByte = 9'h0; cmdLast = 1'b0;
    pixelValid = 1'b0; pixelDataIn = 16'h0;
  endtask

  task automatic waitIdle(input string tag, input int maxCycles);
    int n = 0;
    while (busy !== 1'b0 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_reached"}, 16'(busy), 16'h0);
  endtask

  initial begin
    clearInputs();
    reset_n = 1'b0;

    // ---------------- reset state (requests present, readies must stay low)
    cmdValid = 1'b1; cmdByte = 9'h1AA; pixelValid = 1'b1; pixelDataIn = 16'hBEEF;
    repeat (2) @(negedge clk);
    #1;
    checkBus("reset", 1, 1, 1, 8'h00, 0);
    check("reset_cmdReady", 16'(cmdReady),   16'h0);
    check("reset_pixReady", 16'(pixelReady), 16'h0);
    clearInputs();
    @(negedge clk);
    reset_n = 1'b1;

    // ---------------- vector table
    // single command 0x02A, last
    vecs.push_back(mk("c33_grant", 1, 9'h02A, 1, 0, 16'h0, 1, 0, 1, 1, 1, 8'h00, 0));
    addByte("c33", 0, 16'h0, 0, 8'h2A);
    addHold("c33", CI, 0, 8'h2A);
    vecs.push_back(mk("c33_release", 0, 9'h0, 0, 0, 16'h0, 0, 0, 1, 1, 0, 8'h2A, 0));
    // pixel 0xF81F: MSB then LSB, 10 clocks from grant to HOLD
    vecs.push_back(mk("p34_grant", 0, 9'h0, 0, 1, 16'hF81F, 0, 1, 1, 1, 0, 8'h2A, 0));
    addByte("p34_msb", 0, 16'h0, 1, 8'hF8);
    addByte("p34_lsb", 0, 16'h0, 1, 8'h1F);
    addHold("p34", CI, 1, 8'h1F);
    vecs.push_back(mk("p34_release", 0, 9'h0, 0, 0, 16'h0, 0, 0, 1, 1, 1, 8'h1F, 0));
    // simultaneous cmd 0x12C and pixel 0x1234: cmd first, pixel in next HOLD
    vecs.push_back(mk("s35_grant", 1, 9'h12C, 1, 1, 16'h1234, 1, 0, 1, 1, 1, 8'h1F, 0));
    addByte("s35_cmd", 1, 16'h1234, 1, 8'h2C);
    vecs.push_back(mk("s35_pixgrant", 0, 9'h0, 0, 1, 16'h1234, 0, 1, 0, 1, 1, 8'h2C, 1));
    addByte("s35_msb", 0, 16'h0, 1, 8'h12);
    addByte("s35_lsb", 0, 16'h0, 1, 8'h34);
    addHold("s35", CI, 1, 8'h34);
    vecs.push_back(mk("s35_release", 0, 9'h0, 0, 0, 16'h0, 0, 0, 1, 1, 1, 8'h34, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      cmdValid = vecs[i].cv; cmdByte = vecs[i].cb; cmdLast = vecs[i].cl;
      pixelValid = vecs[i].pv; pixelDataIn = vecs[i].pd;
      #1;
      check({vecs[i].tag, "_cmdReady"}, 16'(cmdReady),   16'(vecs[i].eCmdReady));
      check({vecs[i].tag, "_pixReady"}, 16'(pixelReady), 16'(vecs[i].ePixReady));
      checkBus(vecs[i].tag, vecs[i].eCs, vecs[i].eWr, vecs[i].eDc, vecs[i].ePort, vecs[i].eBusy);
    end
    @(negedge clk);
    clearInputs();

    // ---------------- cmd raised during pixel MSB WR_LOW waits for the LSB
    @(negedge clk);
    pixelValid = 1'b1; pixelDataIn = 16'hABCD;
    #1;
    check("m36_pixgrant", 16'(pixelReady), 16'h1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      pixelValid = 1'b0;
      if (i >= 2) begin
        cmdValid = 1'b1; cmdByte = 9'h0B0; cmdLast = 1'b1;
      end
      #1;
      check($sformatf("m36_nogrant_%0d", i), 16'(cmdReady), 16'h0);
      check($sformatf("m36_cs_low_%0d", i), 16'(tftChipSelect), 16'h0);
      if (i == 1) check("m36_msb_port", 16'(tftParallelPort), 16'hAB);
      if (i == 6) check("m36_lsb_port", 16'(tftParallelPort), 16'hCD);
    end
    @(negedge clk);
    #1;
    check("m36_cmdgrant", 16'(cmdReady), 16'h1);
    checkBus("m36_hold", 0, 1, 1, 8'hCD, 1);
    @(negedge clk);
    clearInputs();
    #1;
    checkBus("m36_cmd_setup", 0, 1, 0, 8'hB0, 1);
    waitIdle("m36", 40);

    // ---------------- lock: cmd 0x02B not last keeps pixels out
    @(negedge clk);
    cmdValid = 1'b1; cmdByte = 9'h02B; cmdLast = 1'b0;
    pixelValid = 1'b1; pixelDataIn = 16'h5566;
    #1;
    check("l37_grant", 16'(cmdReady), 16'h1);
    check("l37_grant_pix", 16'(pixelReady), 16'h0);
    @(negedge clk);
    cmdValid = 1'b0; cmdByte = 9'h0; cmdLast = 1'b0;
    #1;
    checkBus("l37_setup", 0, 1, 0, 8'h2B, 1);
    repeat (WL + WH) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("l37_locked_pix_%0d", i), 16'(pixelReady), 16'h0);
      check($sformatf("l37_locked_cs_%0d", i), 16'(tftChipSelect), 16'h0);
    end
    @(negedge clk);
    cmdValid = 1'b1; cmdByte = 9'h100; cmdLast = 1'b1;
    #1;
    check("l37_final_grant", 16'(cmdReady), 16'h1);
    check("l37_final_pix", 16'(pixelReady), 16'h0);
    @(negedge clk);
    cmdValid = 1'b0; cmdByte = 9'h0; cmdLast = 1'b0;
    #1;
    checkBus("l37_final_setup", 0, 1, 1, 8'h00, 1);
    repeat (WL + WH) @(negedge clk);
    @(negedge clk);
    #1;
    check("l37_unlocked_pix", 16'(pixelReady), 16'h1);
    @(negedge clk);
    clearInputs();
    #1;
    checkBus("l37_pix_setup", 0, 1, 1, 8'h55, 1);
    waitIdle("l37", 60);

    // ---------------- reset during WR_LOW of 0x0FF
    @(negedge clk);
    cmdValid = 1'b1; cmdByte = 9'h0FF; cmdLast = 1'b1;
    #1;
    check("r38_grant", 16'(cmdReady), 16'h1);
    @(negedge clk);
    clearInputs();
    @(negedge clk);
    #1;
    check("r38_in_wrlow", 16'(tftWriteEnable), 16'h0);
    #1;
    reset_n = 1'b0;
    #1;
    checkBus("r38_reset", 1, 1, 1, 8'h00, 0);
    check("r38_reset_cmdReady", 16'(cmdReady), 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("r38_quiet_busy_%0d", i), 16'(busy), 16'h0);
      check($sformatf("r38_quiet_cs_%0d", i), 16'(tftChipSelect), 16'h1);
      check($sformatf("r38_quiet_ready_%0d", i), 16'(cmdReady), 16'h0);
    end
    @(negedge clk);
    cmdValid = 1'b1; cmdByte = 9'h0A5; cmdLast = 1'b1;
    #1;
    check("r38_regrant", 16'(cmdReady), 16'h1);
    @(negedge clk);
    clearInputs();
    #1;
    checkBus("r38_resend_setup", 0, 1, 0, 8'hA5, 1);
    waitIdle("r38", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
